mata_reader: RTL and testbench

- Reads the expanded matrix A (K x L polynomials, N coefficients each, NTT domain) back out of port b of the matA dp_ram_true.
- The RejNTTPoly sampler writes that RAM through port a. This block is the consumer on the other port.
- Emits a tagged coefficient stream with valid/ready backpressure toward the matrix-vector multiply (A·y, A·z) datapath.
- Hides the RAM's 1-cycle synchronous read latency behind a 2-entry buffer, so sustained throughput is 1 coefficient/cycle.

---
 rtl/dilithium_pkg.sv | 34 +++
 rtl/coeff_skid_fifo.sv | 52 +++++
 rtl/mata_reader.sv | 152 +++++++++++++++
 tb/tb_mata_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the tagged coefficient beat carried by the matrix/vector readers.
package dilithium_pkg;

  localparam int K               = 8;
  localparam int L               = 7;
  localparam int N               = 256;
  localparam int COEFF_WIDTH     = 24;
  localparam int Q               = 8380417;
  localparam int MATA_ADDR_WIDTH = $clog2(K * L * N);
  localparam int N_WIDTH         = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } reader_state_t;

  typedef struct packed {
    logic [COEFF_WIDTH-1:0] coeff;
    logic [3:0]             k;
    logic [3:0]             l;
    logic [N_WIDTH-1:0]     n;
    logic                   poly_last;
    logic                   last;
  } beat_t;

  // Row base address k*L*N without a multiplier: L*N = 1792 = 2048 - 256.
  function automatic logic [MATA_ADDR_WIDTH-1:0] row_base(input logic [3:0] k);
    logic [MATA_ADDR_WIDTH:0] diff;
    diff = {k, 11'b0} - {3'b0, k, 8'b0};
    return diff[MATA_ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/coeff_skid_fifo.sv
// Two-deep FIFO of tagged beats; absorbs the RAM read latency so the stream can run at full rate.
module coeff_skid_fifo
  import dilithium_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  beat_t      wr_data,
  output beat_t      rd_data,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  do_push;
  logic  do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);

endmodule

// File: rtl/mata_reader.sv
// Streams matrix A out of port b of the matA RAM as tagged coefficients, whole matrix or one row.
module mata_reader
  import dilithium_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       row_mode,
  input  logic [3:0]                 row_k,
  output logic                       busy,
  output logic                       done,
  output logic                       we_b,
  output logic [MATA_ADDR_WIDTH-1:0] addr_b,
  output logic [COEFF_WIDTH-1:0]     din_b,
  input  logic [COEFF_WIDTH-1:0]     dout_b,
  output logic [COEFF_WIDTH-1:0]     coeff_out,
  output logic [3:0]                 k_out,
  output logic [3:0]                 l_out,
  output logic [N_WIDTH-1:0]         n_out,
  output logic                       poly_last,
  output logic                       last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  reader_state_t      state;
  logic               mode_row;
  logic [3:0]         k_cnt;
  logic [3:0]         l_cnt;
  logic [N_WIDTH-1:0] n_cnt;

  logic               rd_valid;
  logic [3:0]         rd_k;
  logic [3:0]         rd_l;
  logic [N_WIDTH-1:0] rd_n;
  logic               rd_poly_last;
  logic               rd_last;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_count;
  beat_t      fifo_in;
  beat_t      head;

  logic       n_wrap;
  logic       l_wrap;
  logic       is_final;
  logic [2:0] occupancy;
  logic       can_issue;

  assign n_wrap    = (n_cnt == N_WIDTH'(N - 1));
  assign l_wrap    = (l_cnt == 4'(L - 1));
  assign is_final  = n_wrap && l_wrap && (mode_row || (k_cnt == 4'(K - 1)));
  assign occupancy = {1'b0, fifo_count} + {2'b0, rd_valid};
  // A pop in the same cycle frees a slot, which keeps the stream at one beat per cycle.
  assign can_issue = (state == ISSUE) && ((occupancy < 3'd2) || fifo_pop);

  assign fifo_push = rd_valid;
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_in   = '{coeff: dout_b, k: rd_k, l: rd_l, n: rd_n,
                       poly_last: rd_poly_last, last: rd_last};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      addr_b       <= '0;
      mode_row     <= 1'b0;
      k_cnt        <= '0;
      l_cnt        <= '0;
      n_cnt        <= '0;
      rd_valid     <= 1'b0;
      rd_k         <= '0;
      rd_l         <= '0;
      rd_n         <= '0;
      rd_poly_last <= 1'b0;
      rd_last      <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= can_issue;
      case (state)
        IDLE: begin
          if (start && !(row_mode && (row_k >= 4'(K)))) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            mode_row <= row_mode;
            addr_b   <= row_mode ? row_base(row_k) : '0;
            k_cnt    <= row_mode ? row_k : 4'd0;
            l_cnt    <= '0;
            n_cnt    <= '0;
          end
        end
        ISSUE: begin
          if (can_issue) begin
            rd_k         <= k_cnt;
            rd_l         <= l_cnt;
            rd_n         <= n_cnt;
            rd_poly_last <= n_wrap;
            rd_last      <= is_final;
            // The final address is left on addr_b; nothing reads it again.
            if (is_final) begin
              state <= DRAIN;
            end else begin
              addr_b <= addr_b + 1'b1;
              n_cnt  <= n_cnt + 1'b1;
              if (n_wrap) begin
                l_cnt <= l_wrap ? 4'd0 : l_cnt + 4'd1;
                if (l_wrap) begin
                  k_cnt <= k_cnt + 4'd1;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (fifo_pop && head.last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  coeff_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_in),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign coeff_out = head.coeff;
  assign k_out     = head.k;
  assign l_out     = head.l;
  assign n_out     = head.n;
  assign poly_last = head.poly_last;
  assign last      = head.last;
  assign we_b      = 1'b0;
  assign din_b     = '0;

endmodule

// File: tb/tb_mata_reader.sv
// Scoreboard bench for mata_reader: a RAM model preloaded with mem[i] = i, expected beats queued per pass.
module tb_mata_reader;

  typedef struct packed {
    logic [23:0] coeff;
    logic [3:0]  k;
    logic [3:0]  l;
    logic [7:0]  n;
    logic        pl;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        row_mode = 1'b0;
  logic [3:0]  row_k = 4'd0;
  logic        busy;
  logic        done;
  logic        we_b;
  logic [13:0] addr_b;
  logic [23:0] din_b;
  logic [23:0] dout_b = 24'd0;
  logic [23:0] coeff_out;
  logic [3:0]  k_out;
  logic [3:0]  l_out;
  logic [7:0]  n_out;
  logic        poly_last;
  logic        last;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [23:0] mem [0:16383];
  exp_t        exp_q [$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          beat_count = 0;
  int          overflow_cnt = 0;
  int          ready_mode = 0;
  int          t0 = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  exp_t        prev_beat;

  mata_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_mode  (row_mode),
    .row_k     (row_k),
    .busy      (busy),
    .done      (done),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .din_b     (din_b),
    .dout_b    (dout_b),
    .coeff_out (coeff_out),
    .k_out     (k_out),
    .l_out     (l_out),
    .n_out     (n_out),
    .poly_last (poly_last),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Port-b RAM model: one-cycle synchronous read, never written by the reader.
  always @(posedge clk) dout_b <= mem[addr_b];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = ($urandom_range(0, 9) < 3);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  always @(negedge clk) begin
    exp_t act;
    exp_t exp;
    if (!mon_en || rst) begin
      prev_stall = 1'b0;
    end else begin
      act = '{coeff: coeff_out, k: k_out, l: l_out, n: n_out, pl: poly_last, last: last};
      if (prev_stall) checkOutput("stall_hold", 64'({out_valid, act}), 64'({1'b1, prev_beat}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(act), 64'(0));
        end else begin
          exp = exp_q.pop_front();
          checkOutput("beat", 64'(act), 64'(exp));
        end
        beat_count++;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = act;
    end
    if (dut.fifo_push && dut.u_fifo.full) overflow_cnt++;
  end

  task automatic applyStimulus(input logic rm, input logic [3:0] rk);
    int base;
    int beats;
    int idx;
    exp_t e;
    base  = rm ? int'(rk) * 1792 : 0;
    beats = rm ? 1792 : 14336;
    for (int i = 0; i < beats; i++) begin
      idx     = base + i;
      e.coeff = 24'(idx);
      e.k     = 4'(idx / 1792);
      e.l     = 4'((idx / 256) % 7);
      e.n     = 8'(idx % 256);
      e.pl    = ((idx % 256) == 255);
      e.last  = (i == beats - 1);
      exp_q.push_back(e);
    end
    beat_count = 0;
    @(negedge clk);
    start    = 1'b1;
    row_mode = rm;
    row_k    = rk;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic waitValid(input string name, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) checkOutput({name, "_valid_timeout"}, 64'(0), 64'(1));
    else if (exp_lat >= 0) checkOutput({name, "_first_valid"}, 64'(cyc - t0), 64'(exp_lat));
  endtask

  task automatic waitDone(input string name, input int limit, input int ref_cyc, input int exp_lat);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput({name, "_done_timeout"}, 64'(0), 64'(1));
    end else begin
      if (exp_lat >= 0) checkOutput({name, "_done_cycle"}, 64'(cyc - ref_cyc), 64'(exp_lat));
      checkOutput({name, "_busy_at_done"}, 64'(busy), 64'(0));
      @(negedge clk);
      checkOutput({name, "_done_single"}, 64'(done), 64'(0));
      checkOutput({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    end
  endtask

  initial begin
    int r;
    int n;
    int done_seen;
    for (int i = 0; i < 16384; i++) mem[i] = 24'(i);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_addr", 64'(addr_b), 64'(0));
    checkOutput("reset_stream", 64'({coeff_out, k_out, l_out, n_out, poly_last, last}), 64'(0));
    checkOutput("reset_we_din", 64'({we_b, din_b}), 64'(0));
    mon_en = 1'b1;

    $display("[TB] full pass, ready held high");
    applyStimulus(1'b0, 4'd0);
    checkOutput("full_busy", 64'(busy), 64'(1));
    waitValid("full", 2);
    waitDone("full", 15000, t0, 14338);

    $display("[TB] row pass, row_k=3");
    applyStimulus(1'b1, 4'd3);
    waitDone("row3", 2500, t0, 1794);

    $display("[TB] row pass with random backpressure");
    @(negedge clk);
    ready_mode = 1;
    applyStimulus(1'b1, 4'd6);
    waitDone("bp", 20000, t0, -1);
    ready_mode = 0;

    $display("[TB] stall at first beat for 20 cycles");
    @(negedge clk);
    ready_mode = 2;
    applyStimulus(1'b1, 4'd0);
    waitValid("stall", 2);
    repeat (20) @(negedge clk);
    checkOutput("stall_valid", 64'(out_valid), 64'(1));
    checkOutput("stall_first_beat", 64'({coeff_out, k_out, l_out, n_out}), 64'(0));
    ready_mode = 0;
    @(posedge clk);
    #2;
    r = cyc;
    waitDone("stall", 2500, r, 1792);

    $display("[TB] start ignored mid-pass");
    applyStimulus(1'b1, 4'd5);
    fork
      begin
        repeat (100) @(negedge clk);
        start    = 1'b1;
        row_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      waitDone("ignored", 2500, t0, 1794);
    join

    $display("[TB] invalid row index");
    @(negedge clk);
    start    = 1'b1;
    row_mode = 1'b1;
    row_k    = 4'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bad_row_busy", 64'(busy), 64'(0));
      checkOutput("bad_row_valid", 64'(out_valid), 64'(0));
    end

    $display("[TB] reset mid-pass at beat 500");
    applyStimulus(1'b0, 4'd0);
    n = 0;
    while (beat_count < 500 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reset_reach_beat500", 64'(beat_count >= 500), 64'(1));
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_done", 64'(done), 64'(0));
    exp_q.delete();
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("midreset_no_done", 64'(done_seen), 64'(0));
    mon_en = 1'b1;

    $display("[TB] fresh full pass after reset");
    applyStimulus(1'b0, 4'd0);
    waitValid("restart", 2);
    waitDone("restart", 15000, t0, 14338);

    checkOutput("fifo_overflow", 64'(overflow_cnt), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
